pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
// Generic elastic pipeline-stage register for the lc3b pipeline; replaces fixed load/clear stage regs (IF/ID, ID/EX, ...).
// Valid/ready handshake on both sides plus a 1-entry skid buffer, so in_ready is purely registered and a
// downstream stall never combinationally reaches the upstream stage. Flush squashes in-flight instructions
// and drives a NOP bubble. Payload is an opaque packed vector (pc, ir, prediction bit, ...).
// PARAMETERS
// WIDTH      16  payload width in bits (IF/ID instance: 16 pc + 16 ir + 1 prediction = 33)
// SKID        1  1 = skid entry present (registered in_ready); 0 = plain stage, in_ready = out_ready | !out_valid
// NOP_VALUE  '0  payload driven on out_data while out_valid=0 and loaded on reset/flush (0x0000 = lc3b BR never)
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      synchronous, active-high reset
// flush      in   1      squash all held entries (branch mispredict / redirect)
// in_valid   in   1      upstream presents in_data
// in_data    in   WIDTH  upstream payload
// in_ready   out  1      stage can accept in_data this cycle
// out_valid  out  1      out_data is a live instruction
// out_data   out  WIDTH  payload to downstream stage
// out_ready  in   1      downstream accepts out_data this cycle
// occupancy  out  2      number of held entries, 0..2 (0..1 when SKID=0)
// BEHAVIOUR
// - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both evaluated at the same edge.
// - Reset: out_valid=0, out_data=NOP_VALUE, skid empty, in_ready=1, occupancy=0. Next cycle fully usable.
// - Latency 1: data accepted at edge N is on out_data after edge N when the main entry is empty or draining.
// - States (SKID=1): EMPTY(occ 0), ONE(main valid), FULL(main+skid valid). in_ready = (state != FULL), registered.
//   EMPTY: in -> ONE. ONE: in & !out -> FULL (data into skid); in & out -> ONE (main reloads); !in & out -> EMPTY.
//   FULL: out -> ONE (skid moves to main, order preserved); no input accepted while FULL.
// - Ordering: strict FIFO; skid content always older than any later accept; never reorder or duplicate.
// - out_data/out_valid stable while out_valid & !out_ready (no change until transfer or flush).
// - Flush: highest priority after reset; at the flush edge both entries invalidated, out_data=NOP_VALUE,
//   state EMPTY, in_ready=1 next cycle. An in transfer in the flush cycle is discarded. Out transfer in the
//   flush cycle still counts as completed (downstream saw it before the edge).
// - reset and flush together: reset semantics (identical result).
// - SKID=0: single entry; in_ready = out_ready | !out_valid (combinational); flush/reset as above.
// - occupancy equals count of valid entries after each edge; never exceeds 2.
// - No combinational path in_valid->in_ready or out_ready->in_ready when SKID=1.
// STRUCTURE
// - lc3b_types gains: typedef struct packed {lc3b_word pc; lc3b_word ir; logic prediction;} lc3b_if_id_t;
//   localparam lc3b_word LC3B_NOP = 16'h0000. Instances pass $bits(lc3b_if_id_t) as WIDTH.
// - Main and skid payloads use register_with_clear (clear driven by reset|flush, loaded with NOP via mux);
//   control state (2-bit) is local always_ff. Field decode (opcode, dest, src1/2) stays outside.
// - Generate block selects SKID=0/1 control; no other sub-module.
// TESTING
// 1 reset=1 two cycles -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
// 2 out_ready=1, stream 0x3000,0x3002,0x3004 one per cycle -> same order on out_data, 1-cycle latency, no stalls.
// 3 out_ready=0, send A=0x1111,B=0x2222 -> occupancy=2, in_ready=0 after 2nd edge; C=0x3333 held upstream;
//   release out_ready -> A,B,C emitted in order, none lost/duplicated.
// 4 FULL state + flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=NOP, occupancy=0, in_ready=1,
//   flushed-cycle input never appears.
// 5 ONE state, in_valid=1 and out_ready=1 same cycle -> stays ONE, new word on out_data, occupancy=1.
// 6 SKID=0 build, random in_valid/out_ready 10k cycles vs scoreboard -> exact order match; assert in_ready
//   never 1 while out_valid & !out_ready.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the lc3b elastic pipeline stage.
//   lc3b_word      16-bit machine word
//   lc3b_if_id_t   IF/ID payload (pc, ir, prediction); instances pass $bits() as WIDTH
//   LC3B_NOP       bubble encoding (BR never)
//   stage_state_e  held-entry state of a pipe_stage_skid instance
package pipe_stage_skid_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
    logic     prediction;
  } lc3b_if_id_t;

  localparam lc3b_word LC3B_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] state_occupancy(stage_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// register_with_clear: payload register with synchronous clear to a constant.
//   clk      rising-edge clock
//   i_clear  load CLEAR_VALUE (priority over i_load)
//   i_load   capture i_d
//   i_d      next value
//   o_q      registered value
module register_with_clear #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_q <= CLEAR_VALUE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with optional 1-entry skid.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   flush       squash all held entries, drive NOP bubble
//   in_valid / in_data / in_ready     upstream handshake
//   out_valid / out_data / out_ready  downstream handshake
//   occupancy   number of held entries (0..2)
// With SKID=1 in_ready depends only on the state register, so a downstream
// stall never reaches upstream combinationally.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  stage_state_e     r_state;
  stage_state_e     w_state_nxt;
  logic             w_clear;
  logic             w_xfer_in;
  logic             w_xfer_out;
  logic             w_main_ld;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_clear    = reset | flush;
  assign w_xfer_in  = in_valid & in_ready;
  assign w_xfer_out = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state (ONE -> FULL is unreachable in the plain build: in_ready is low
  // there whenever out_ready is low)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer_in) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_xfer_in && !w_xfer_out) begin
          w_state_nxt = ST_FULL;
        end else if (!w_xfer_in && w_xfer_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL:  if (w_xfer_out) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (r_state != ST_EMPTY);
    occupancy = state_occupancy(r_state);
  end

  // Main entry: refills from input, from skid, or drops to NOP when draining empty
  always_comb begin
    w_main_ld = 1'b0;
    w_main_d  = in_data;
    case (r_state)
      ST_EMPTY: w_main_ld = w_xfer_in;
      ST_ONE: begin
        if (w_xfer_out) begin
          w_main_ld = 1'b1;
          w_main_d  = w_xfer_in ? in_data : NOP_VALUE;
        end
      end
      ST_FULL: begin
        if (w_xfer_out) begin
          w_main_ld = 1'b1;
          w_main_d  = w_skid_q;
        end
      end
      default: w_main_ld = 1'b0;
    endcase
  end

  register_with_clear #(
    .WIDTH       (WIDTH),
    .CLEAR_VALUE (NOP_VALUE)
  ) u_main (
    .clk     (clk),
    .i_clear (w_clear),
    .i_load  (w_main_ld),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  assign out_data = w_main_q;

  generate
    if (SKID) begin : g_skid
      logic             w_skid_ld;
      logic [WIDTH-1:0] w_skid_d;

      // Skid catches the word accepted while the main entry stalls, and
      // returns to NOP once it has moved into the main entry.
      always_comb begin
        w_skid_ld = 1'b0;
        w_skid_d  = in_data;
        if (r_state == ST_ONE && w_xfer_in && !w_xfer_out) begin
          w_skid_ld = 1'b1;
        end else if (r_state == ST_FULL && w_xfer_out) begin
          w_skid_ld = 1'b1;
          w_skid_d  = NOP_VALUE;
        end
      end

      register_with_clear #(
        .WIDTH       (WIDTH),
        .CLEAR_VALUE (NOP_VALUE)
      ) u_skid (
        .clk     (clk),
        .i_clear (w_clear),
        .i_load  (w_skid_ld),
        .i_d     (w_skid_d),
        .o_q     (w_skid_q)
      );

      assign in_ready = (r_state != ST_FULL);
    end else begin : g_plain
      assign w_skid_q = NOP_VALUE;
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table and hand sequences on the
// SKID=1 build, then randomized traffic on SKID=1 and SKID=0 builds compared
// against a queue model of a bounded FIFO.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [15:0] s_in_data = '0;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_data;
  logic [1:0]  s_occ;

  // SKID=0 instance
  logic        p_flush = 1'b0, p_in_valid = 1'b0, p_out_ready = 1'b0;
  logic [15:0] p_in_data = '0;
  logic        p_in_ready, p_out_valid;
  logic [15:0] p_out_data;
  logic [1:0]  p_occ;

  pipe_stage_skid #(.WIDTH(16), .SKID(1'b1), .NOP_VALUE(16'h0000)) dut_skid (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .occupancy(s_occ)
  );

  pipe_stage_skid #(.WIDTH(16), .SKID(1'b0), .NOP_VALUE(16'h0000)) dut_plain (
    .clk(clk), .reset(reset), .flush(p_flush),
    .in_valid(p_in_valid), .in_data(p_in_data), .in_ready(p_in_ready),
    .out_valid(p_out_valid), .out_data(p_out_data), .out_ready(p_out_ready),
    .occupancy(p_occ)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_ready;
    logic [1:0]  exp_occ;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  // Bounded FIFO models
  logic [15:0] q_s[$];
  logic [15:0] q_p[$];

  initial begin
    // name, flush, in_valid, in_data, out_ready | valid, data, in_ready, occ
    vecs[0]  = '{"stream0",   1'b0, 1'b1, 16'h3000, 1'b1, 1'b1, 16'h3000, 1'b1, 2'd1};
    vecs[1]  = '{"stream1",   1'b0, 1'b1, 16'h3002, 1'b1, 1'b1, 16'h3002, 1'b1, 2'd1};
    vecs[2]  = '{"stream2",   1'b0, 1'b1, 16'h3004, 1'b1, 1'b1, 16'h3004, 1'b1, 2'd1};
    vecs[3]  = '{"drain",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0};
    vecs[4]  = '{"stallA",    1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h1111, 1'b1, 2'd1};
    vecs[5]  = '{"stallB",    1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h1111, 1'b0, 2'd2};
    vecs[6]  = '{"holdC",     1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 16'h1111, 1'b0, 2'd2};
    vecs[7]  = '{"relA",      1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h2222, 1'b1, 2'd1};
    vecs[8]  = '{"relB",      1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h3333, 1'b1, 2'd1};
    vecs[9]  = '{"relC",      1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0};
    vecs[10] = '{"fillA",     1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 16'hAAAA, 1'b1, 2'd1};
    vecs[11] = '{"fillB",     1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b1, 16'hAAAA, 1'b0, 2'd2};
    vecs[12] = '{"flushFull", 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0};
    vecs[13] = '{"postFlush", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0};
    vecs[14] = '{"load1234",  1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1, 2'd1};
    vecs[15] = '{"flushXfer", 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0};
    vecs[16] = '{"load7777",  1'b0, 1'b1, 16'h7777, 1'b0, 1'b1, 16'h7777, 1'b1, 2'd1};

    // Reset: two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  {31'd0, s_out_valid}, 32'd0);
    chk("rst_data",   {16'd0, s_out_data},  32'd0);
    chk("rst_ready",  {31'd0, s_in_ready},  32'd1);
    chk("rst_occ",    {30'd0, s_occ},       32'd0);
    chk("rst_valid0", {31'd0, p_out_valid}, 32'd0);
    chk("rst_ready0", {31'd0, p_in_ready},  32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      s_flush     = vecs[i].flush;
      s_in_valid  = vecs[i].in_valid;
      s_in_data   = vecs[i].in_data;
      s_out_ready = vecs[i].out_ready;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_valid"}, {31'd0, s_out_valid}, {31'd0, vecs[i].exp_valid});
      chk({vecs[i].name, "_data"},  {16'd0, s_out_data},  {16'd0, vecs[i].exp_data});
      chk({vecs[i].name, "_ready"}, {31'd0, s_in_ready},  {31'd0, vecs[i].exp_ready});
      chk({vecs[i].name, "_occ"},   {30'd0, s_occ},       {30'd0, vecs[i].exp_occ});
    end

    // Fill to FULL behind 0x7777, then raise out_ready mid-cycle:
    // in_ready must not react before the edge.
    @(negedge clk);
    s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 16'h8888; s_out_ready = 1'b0;
    @(negedge clk);
    s_in_data = 16'h9999; s_out_ready = 1'b1;
    #1;
    chk("nocomb_ready", {31'd0, s_in_ready}, 32'd0);
    chk("nocomb_occ",   {30'd0, s_occ},      32'd2);
    chk("nocomb_data",  {16'd0, s_out_data}, 32'h7777);
    @(posedge clk);
    #1;
    chk("skid2main_data",  {16'd0, s_out_data}, 32'h8888);
    chk("skid2main_occ",   {30'd0, s_occ},      32'd1);
    chk("skid2main_ready", {31'd0, s_in_ready}, 32'd1);

    // reset and flush together
    @(negedge clk);
    reset = 1'b1; s_flush = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDEAD; s_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rstflush_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rstflush_data",  {16'd0, s_out_data},  32'd0);
    chk("rstflush_ready", {31'd0, s_in_ready},  32'd1);
    chk("rstflush_occ",   {30'd0, s_occ},       32'd0);

    // Randomized traffic on both builds
    @(negedge clk);
    s_flush = 1'b0; s_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_s.delete();
    q_p.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic        e_ready, e_valid;
      logic [15:0] e_data;
      @(negedge clk);
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_in_data   = 16'($urandom);
      s_out_ready = ($urandom_range(0, 1) != 0);
      s_flush     = ($urandom_range(0, 63) == 0);
      p_in_valid  = ($urandom_range(0, 3) != 0);
      p_in_data   = 16'($urandom);
      p_out_ready = ($urandom_range(0, 2) != 0);
      p_flush     = ($urandom_range(0, 63) == 0);
      #1;

      // SKID=1: two-deep FIFO, accepts whenever not full
      e_ready = (q_s.size() < 2);
      e_valid = (q_s.size() > 0);
      e_data  = e_valid ? q_s[0] : 16'h0000;
      chk("rnd_s_ready", {31'd0, s_in_ready},  {31'd0, e_ready});
      chk("rnd_s_valid", {31'd0, s_out_valid}, {31'd0, e_valid});
      chk("rnd_s_data",  {16'd0, s_out_data},  {16'd0, e_data});
      chk("rnd_s_occ",   {30'd0, s_occ},       32'(q_s.size()));
      if (s_flush) begin
        q_s.delete();
      end else begin
        if (e_valid && s_out_ready) void'(q_s.pop_front());
        if (s_in_valid && e_ready) q_s.push_back(s_in_data);
      end

      // SKID=0: one-deep, accepts when empty or draining this cycle
      e_valid = (q_p.size() > 0);
      e_ready = p_out_ready || !e_valid;
      e_data  = e_valid ? q_p[0] : 16'h0000;
      chk("rnd_p_ready", {31'd0, p_in_ready},  {31'd0, e_ready});
      chk("rnd_p_valid", {31'd0, p_out_valid}, {31'd0, e_valid});
      chk("rnd_p_data",  {16'd0, p_out_data},  {16'd0, e_data});
      chk("rnd_p_occ",   {30'd0, p_occ},       32'(q_p.size()));
      chk("rnd_p_nostall", {31'd0, p_in_ready & p_out_valid & ~p_out_ready}, 32'd0);
      if (p_flush) begin
        q_p.delete();
      end else begin
        if (e_valid && p_out_ready) void'(q_p.pop_front());
        if (p_in_valid && e_ready) q_p.push_back(p_in_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
